// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the round-robin shift scheduler.
// Holds the shift opcode enum, the command bundle and datapath widths.
package shift_sched_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROT = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [AMT_W-1:0]  shift_amt;
        shift_op_e         op;
        logic              dir;
    } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter_32.sv
// Combinational 32-bit shifter: LSL, LSR, ASR and rotate (dir 0 left, 1 right).
// Ports: i_cmd (operand, amount, op, dir) -> o_q (shifted result).
module barrel_shifter_32
    import shift_sched_pkg::*;
(
    input  shift_cmd_t        i_cmd,
    output logic [DATA_W-1:0] o_q
);

    logic [2*DATA_W-1:0] w_dd;
    logic [2*DATA_W-1:0] w_rotl;
    logic [2*DATA_W-1:0] w_rotr;

    // Rotates come from shifting the doubled operand; amt=0 naturally yields d.
    always_comb begin
        w_dd   = {i_cmd.d, i_cmd.d};
        w_rotl = w_dd << i_cmd.shift_amt;
        w_rotr = w_dd >> i_cmd.shift_amt;
        o_q    = '0;
        unique case (i_cmd.op)
            OP_LSL: o_q = i_cmd.d << i_cmd.shift_amt;
            OP_LSR: o_q = i_cmd.d >> i_cmd.shift_amt;
            OP_ASR: o_q = $signed(i_cmd.d) >>> i_cmd.shift_amt;
            OP_ROT: o_q = i_cmd.dir ? w_rotr[DATA_W-1:0]
                                    : w_rotl[2*DATA_W-1:DATA_W];
        endcase
    end

endmodule

// File: rtl/shift_sched_rr_arb.sv
// Combinational round-robin arbiter: first valid request at or after ptr, wrapping.
// Ports: i_req[N], i_ptr -> o_gnt (one-hot, 0 if idle), o_gnt_idx (encoded).
module rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx[ID_W-1:0];
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_sched_rr.sv
// Round-robin scheduler sharing one barrel_shifter_32 among NUM_REQ requesters,
// with a one-entry registered output tagged by requester ID.
// Ports: clk, rst_n (async low); req_valid/req_ready/req_d/req_shift_amt/req_op/
// req_dir per requester; rsp_valid/rsp_ready/rsp_data/rsp_id result stage.
// Optional SHIFT_SCHED_STATS_EN adds grant_cnt: saturating 16-bit handshake counts.
module shift_sched_rr
    import shift_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_d,
    input  logic [NUM_REQ*AMT_W-1:0]  req_shift_amt,
    input  logic [NUM_REQ*2-1:0]      req_op,
    input  logic [NUM_REQ-1:0]        req_dir,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
`ifdef SHIFT_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    logic [ID_W-1:0]    r_ptr;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [ID_W-1:0]    r_id;

    logic               w_accept;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_fire;
    shift_cmd_t         w_cmd;
    logic [DATA_W-1:0]  w_q;
    logic [ID_W-1:0]    w_ptr_nxt;

    assign w_accept = !r_valid || rsp_ready;

    rr_arb #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // Gated by rst_n so no requester sees ready while the block is held in reset.
    assign req_ready = w_gnt & {NUM_REQ{w_accept & rst_n}};
    assign w_fire    = |req_ready;

    always_comb begin
        w_cmd.d         = req_d[DATA_W*w_gnt_idx +: DATA_W];
        w_cmd.shift_amt = req_shift_amt[AMT_W*w_gnt_idx +: AMT_W];
        w_cmd.op        = shift_op_e'(req_op[2*w_gnt_idx +: 2]);
        w_cmd.dir       = req_dir[w_gnt_idx];
    end

    barrel_shifter_32 u_shift (
        .i_cmd (w_cmd),
        .o_q   (w_q)
    );

    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (w_fire) begin
            r_ptr   <= w_ptr_nxt;
            r_valid <= 1'b1;
            r_data  <= w_q;
            r_id    <= w_gnt_idx;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

`ifdef SHIFT_SCHED_STATS_EN
    logic [15:0] r_cnt [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g] <= '0;
            end else if (req_ready[g] && r_cnt[g] != 16'hFFFF) begin
                r_cnt[g] <= r_cnt[g] + 16'd1;
            end
        end
        assign grant_cnt[16*g +: 16] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_shift_sched_rr.sv
// Directed self-checking bench for shift_sched_rr (NUM_REQ=4).
// Covers reset, op coverage, contention, backpressure, async reset, stats.
module tb_shift_sched_rr;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_d;
    logic [19:0]  req_shift_amt;
    logic [7:0]   req_op;
    logic [3:0]   req_dir;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
`ifdef SHIFT_SCHED_STATS_EN
    logic [63:0]  grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    shift_sched_rr #(.NUM_REQ(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_d         (req_d),
        .req_shift_amt (req_shift_amt),
        .req_op        (req_op),
        .req_dir       (req_dir),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id)
`ifdef SHIFT_SCHED_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d,
                           input logic [4:0] amt, input logic [1:0] op,
                           input logic dir);
        req_d[32*i +: 32]       = d;
        req_shift_amt[5*i +: 5] = amt;
        req_op[2*i +: 2]        = op;
        req_dir[i]              = dir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [4:0]  amt;
        logic [1:0]  op;
        logic        dir;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   gcnt[4];
    int   gmin;
    int   gmax;
    logic [31:0] held_d;

    initial begin
        vecs[0] = '{32'hF0000000, 5'd3, 2'b10, 1'b0, 32'hFE000000};
        vecs[1] = '{32'h80000000, 5'd4, 2'b01, 1'b0, 32'h08000000};
        vecs[2] = '{32'h12345678, 5'd8, 2'b11, 1'b0, 32'h34567812};
        vecs[3] = '{32'h87654321, 5'd8, 2'b11, 1'b1, 32'h21876543};
        vecs[4] = '{32'hCAFEBABE, 5'd0, 2'b11, 1'b1, 32'hCAFEBABE};

        rst_n         = 1'b0;
        req_valid     = 4'b0001;
        req_d         = '0;
        req_shift_amt = '0;
        req_op        = '0;
        req_dir       = '0;
        rsp_ready     = 1'b0;
        #12;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id", {30'd0, rsp_id}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // single request, LSL
        set_req(0, 32'h1, 5'd1, 2'b00, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        check("single_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        check("single_valid", {31'd0, rsp_valid}, 32'd1);
        check("single_data", rsp_data, 32'h2);
        check("single_id", {30'd0, rsp_id}, 32'd0);

        // op coverage on requester 2, back to back
        for (int k = 0; k < 5; k++) begin
            set_req(2, vecs[k].d, vecs[k].amt, vecs[k].op, vecs[k].dir);
            req_valid = 4'b0100;
            #1;
            check($sformatf("op%0d_ready", k), {28'd0, req_ready}, 32'h4);
            tick();
            check($sformatf("op%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("op%0d_data", k), rsp_data, vecs[k].exp);
            check($sformatf("op%0d_id", k), {30'd0, rsp_id}, 32'd2);
        end
        req_valid = '0;
        tick();
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);
        check("drain_data", rsp_data, 32'hCAFEBABE);
        check("drain_id", {30'd0, rsp_id}, 32'd2);

        // reset pulse to bring the pointer back to 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // contention: all four valid
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'h100 + i, 5'd0, 2'b00, 1'b0);
            gcnt[i] = 0;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("rr%0d_id", k), {30'd0, rsp_id}, k % 4);
            check($sformatf("rr%0d_data", k), rsp_data, 32'h100 + (k % 4));
            gcnt[rsp_id]++;
        end
        gmin = gcnt[0];
        gmax = gcnt[0];
        for (int i = 1; i < 4; i++) begin
            if (gcnt[i] < gmin) gmin = gcnt[i];
            if (gcnt[i] > gmax) gmax = gcnt[i];
        end
        check("rr_fair", (gmax - gmin <= 1) ? 32'd1 : 32'd0, 32'd1);
        req_valid = '0;

        // backpressure with requester 1 waiting
        rsp_ready = 1'b0;
        set_req(1, 32'h11, 5'd4, 2'b00, 1'b0);
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_ready", k), {28'd0, req_ready}, 32'd0);
            tick();
            check($sformatf("bp%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_id", k), {30'd0, rsp_id}, 32'd3);
            check($sformatf("bp%0d_data", k), rsp_data, 32'h103);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        check("bp_new_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_new_id", {30'd0, rsp_id}, 32'd1);
        check("bp_new_data", rsp_data, 32'h110);

        // asynchronous reset while a result is pending
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_data", rsp_data, 32'd0);
        check("arst_id", {30'd0, rsp_id}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(0, 32'hA, 5'd1, 2'b01, 1'b0);
        set_req(3, 32'hB, 5'd0, 2'b00, 1'b0);
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        #1;
        check("arst_ptr_ready", {28'd0, req_ready}, 32'h1);
        tick();
        check("arst_first_id", {30'd0, rsp_id}, 32'd0);
        check("arst_first_data", rsp_data, 32'h5);
        req_valid = 4'b1000;
        tick();
        check("arst_second_id", {30'd0, rsp_id}, 32'd3);
        check("arst_second_data", rsp_data, 32'hB);
        req_valid = '0;

`ifdef SHIFT_SCHED_STATS_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("cnt_rst", grant_cnt[31:0], 32'd0);
        held_d    = 32'h1;
        set_req(0, held_d, 5'd0, 2'b00, 1'b0);
        req_valid = 4'b0001;
        tick();
        repeat (3) tick();
        check("cnt_four", {16'd0, grant_cnt[15:0]}, 32'd4);
        repeat (65540) tick();
        req_valid = '0;
        check("cnt_sat", {16'd0, grant_cnt[15:0]}, 32'h0000FFFF);
        check("cnt_other", {16'd0, grant_cnt[31:16]}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
